// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use hazard unit for the MISC-V pipeline
//
// Tracks the destination tags of the instructions in EX, MEM and WB and
// derives, for the instruction currently in EX, where each source operand
// must come from. Also raises the load-use stall for the instruction in ID.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   id_valid         an instruction is present in ID
//   id_rs            ID source addresses, source i at [i*REG_AW +: REG_AW]
//   id_rs_used       source i is actually read
//   id_rd            ID destination address
//   id_rd_we         ID instruction writes id_rd
//   id_is_load       ID instruction is a load
//   hold             freeze every stage (memory wait)
//   flush            squash the ID and EX instructions (taken branch)
//   stall            load-use stall: ID holds, a bubble enters EX
//   fwd_sel          per-source select at [2*i +: 2]: 0 MEM, 1 WB, 2 register file
//   fwd_same         0 when MEM and WB both write the same register, else 1
//   stall_count      saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int REG_AW   = 3,
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NSRC*REG_AW-1:0]   id_rs,
    input  logic [NSRC-1:0]          id_rs_used,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_rd_we,
    input  logic                     id_is_load,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     stall,
    output logic [2*NSRC-1:0]        fwd_sel,
    output logic                     fwd_same,
    output logic [CNT_W-1:0]         stall_count
);

    localparam logic [1:0] SEL_MEM = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_RF  = 2'd2;

    // EX stage
    logic                   ex_valid;
    logic [NSRC*REG_AW-1:0] ex_rs;
    logic [NSRC-1:0]        ex_rs_used;
    logic [REG_AW-1:0]      ex_rd;
    logic                   ex_we;
    logic                   ex_load;
    // MEM stage
    logic                   mem_valid;
    logic [REG_AW-1:0]      mem_rd;
    logic                   mem_we;
    // WB stage
    logic                   wb_valid;
    logic [REG_AW-1:0]      wb_rd;
    logic                   wb_we;

    // Register 0 is hardwired when ZERO_REG is set, so it never names a
    // real dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] b);
        return (a == b) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic load_hit;

    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_rs_used[i] && reg_match(id_rs[i*REG_AW +: REG_AW], ex_rd)) begin
                load_hit = 1'b1;
            end
        end
        // A flush kills the ID consumer, so there is nothing to stall for.
        stall = !flush && id_valid && ex_valid && ex_we && ex_load && load_hit;
    end

    // MEM is checked first: it holds the newer result of the two.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            fwd_sel[2*i +: 2] = SEL_RF;
            if (ex_valid && ex_rs_used[i]) begin
                if (mem_valid && mem_we && reg_match(ex_rs[i*REG_AW +: REG_AW], mem_rd)) begin
                    fwd_sel[2*i +: 2] = SEL_MEM;
                end else if (wb_valid && wb_we && reg_match(ex_rs[i*REG_AW +: REG_AW], wb_rd)) begin
                    fwd_sel[2*i +: 2] = SEL_WB;
                end
            end
        end
    end

    // Alias detection is on raw addresses; register 0 is not excluded here.
    assign fwd_same = !(mem_valid && wb_valid && mem_we && wb_we && (mem_rd == wb_rd));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rs_used  <= '0;
            ex_rd       <= '0;
            ex_we       <= 1'b0;
            ex_load     <= 1'b0;
            mem_valid   <= 1'b0;
            mem_rd      <= '0;
            mem_we      <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_we       <= 1'b0;
            stall_count <= '0;
        end else begin
            if (flush) begin
                wb_valid  <= mem_valid;
                wb_rd     <= mem_rd;
                wb_we     <= mem_we;
                mem_valid <= 1'b0;
                ex_valid  <= 1'b0;
            end else if (!hold) begin
                wb_valid  <= mem_valid;
                wb_rd     <= mem_rd;
                wb_we     <= mem_we;
                mem_valid <= ex_valid;
                mem_rd    <= ex_rd;
                mem_we    <= ex_we;
                if (id_valid && !stall) begin
                    ex_valid   <= 1'b1;
                    ex_rs      <= id_rs;
                    ex_rs_used <= id_rs_used;
                    ex_rd      <= id_rd;
                    ex_we      <= id_rd_we;
                    ex_load    <= id_is_load;
                end else begin
                    ex_valid   <= 1'b0;
                end
            end

            // stall is already forced low under flush, so no extra gating.
            if (stall && !hold && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the MISC-V pipeline.
- Tracks in-flight destination tags internally through EX, MEM and WB stages.
- Produces per-source operand forward selects for the EX-stage instruction and a load-use stall for ID.
- Supports flush, global hold, a hardwired zero register and a saturating stall-event counter.

Parameters:
- REG_AW, 3, register address width.
- NSRC, 2, number of source operands per instruction.
- ZERO_REG, 1, if 1 register 0 never matches (never forwarded, never stalls).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID instruction present.
- id_rs  in  NSRC*REG_AW  ID source addresses; source i occupies bits [i*REG_AW +: REG_AW].
- id_rs_used  in  NSRC  source i actually read.
- id_rd  in  REG_AW  ID destination.
- id_rd_we  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load.
- hold  in  1  freeze whole pipeline (memory wait).
- flush  in  1  squash the ID and EX instructions (taken branch).
- stall  out  1  load-use stall: ID must hold and a bubble enters EX.
- fwd_sel  out  2*NSRC  per-source select: 0 = MEM result, 1 = WB result, 2 = register file.
- fwd_same  out  1  0 when the MEM and WB destinations match and both write, else 1.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Stage registers:
  - EX: valid, rs[NSRC], rs_used, rd, we, load.
  - MEM: valid, rd, we, load.
  - WB: valid, rd, we.
- "Match(a,b)" means a == b, and additionally, when ZERO_REG=1, a != 0.
- Reset (rst_n=0 at a clk edge):
  - All stage valids clear and stall_count is zeroed.
  - Outputs then read fwd_sel=2 for every source, fwd_same=1, stall=0.
- stall (combinational):
  - Asserted when id_valid && EX.valid && EX.we && EX.load && there exists some i with id_rs_used[i] && Match(id_rs[i], EX.rd).
  - Forced to 0 while flush=1.
- Update priority per clk edge: rst_n=0 > flush > hold > normal advance.
- Flush: EX <= bubble, MEM <= bubble, WB <= MEM.
- Hold: all stage registers keep their values.
- Normal advance:
  - WB <= MEM and MEM <= EX.
  - If id_valid && !stall, EX <= ID fields; otherwise EX <= bubble (valid=0).
- fwd_sel[i] (combinational from stage registers, so latency is one cycle after ID acceptance):
  - Equals 2 unless EX.valid && EX.rs_used[i].
  - Otherwise 0 if MEM.valid && MEM.we && Match(EX.rs[i], MEM.rd).
  - Else 1 if WB.valid && WB.we && Match(EX.rs[i], WB.rd).
  - Else 2.
  - MEM always has priority over WB (newest value wins).
- fwd_same:
  - 0 iff MEM.valid && WB.valid && MEM.we && WB.we && MEM.rd == WB.rd (zero-register exclusion does not apply).
  - Otherwise 1.
- stall_count: increments on edges where stall=1 && hold=0 && rst_n=1; saturates at all-ones.
- A load in MEM never faces a consumer in EX: the one-cycle bubble guarantees that load data is taken from WB.
- Each source is evaluated independently. Sources naming the same register get identical selects.
- Hold with stall=1: the stall remains asserted for the duration of the hold and the count does not advance.

Test Plan:
- Reset-then-idle: hold rst_n=0 for 2 cycles, then release with no instructions -> fwd_sel=2 on every source, fwd_same=1, stall=0, stall_count=0.
- ALU back-to-back: issue A (rd=3, we) then B (rs0=3, rs1=5) -> with B in EX, fwd_sel[0]=0 and fwd_sel[1]=2; one cycle later, with a C that reads r3 in EX, fwd_sel[0]=1.
- Load-use: load with rd=4 followed by a consumer with rs1=4:
  - stall=1 for exactly 1 cycle and a bubble enters EX.
  - Consumer then reaches EX with fwd_sel[1]=1.
  - stall_count=1.
- Priority and alias: A (rd=2), B (rd=2), then C reads r2 -> fwd_sel=0 (from B), fwd_same=0 during that cycle.
- Zero register with ZERO_REG=1:
  - Producer rd=0, consumer rs0=0 -> fwd_sel[0]=2.
  - A load with rd=0 followed by a consumer of r0 -> stall=0.
- Flush and hold:
  - Load in EX, consumer in ID, flush=1 -> stall=0, EX and MEM become bubbles, count unchanged.
  - Stall pending with hold=1 for 3 cycles -> state frozen, stall stays 1, count unchanged until hold drops.
